load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage load/store unit. Issues word-aligned requests to the data cache over a valid/ready request channel and a valid-only response channel.
- Produces the aligned, sign/zero-extended load value that feeds the write-back mux's cache-data input.
- Asserts a pipeline stall while an access is outstanding.
- Supports RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.

Parameters:
- DATA_WIDTH, 32, data bus and register width (only 32 supported).
- ADDR_WIDTH, 32, byte address width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- MEM_READ_IN  input  1  load instruction in memory stage.
- MEM_WRITE_IN  input  1  store instruction in memory stage.
- FUNCT3_IN  input  3  RV32I funct3 of the load/store.
- ADDRESS_IN  input  ADDR_WIDTH  effective byte address (ALU result).
- STORE_DATA_IN  input  DATA_WIDTH  rs2 value for stores.
- CACHE_REQ_VALID  output  1  request valid.
- CACHE_REQ_READY  input  1  cache accepts request.
- CACHE_REQ_WRITE  output  1  1 = store, 0 = load.
- CACHE_REQ_ADDR  output  ADDR_WIDTH  word address; bits [1:0] forced to 0.
- CACHE_REQ_WDATA  output  DATA_WIDTH  lane-replicated store data.
- CACHE_REQ_WSTRB  output  4  byte enables; 0 for loads.
- CACHE_RESP_VALID  input  1  load data valid.
- CACHE_RESP_DATA  input  DATA_WIDTH  full word read from cache.
- DATA_CACHE_OUT_DATA  output  DATA_WIDTH  extended load result to write-back.
- LOAD_DONE  output  1  one-cycle pulse when DATA_CACHE_OUT_DATA is updated.
- STALL_OUT  output  1  freeze pipeline stages up to memory.
- MISALIGNED_OUT  output  1  misaligned-access flag, combinational.

Behaviour:
- Reset (async, RST_N low): state IDLE; CACHE_REQ_VALID, LOAD_DONE = 0; DATA_CACHE_OUT_DATA, latched request regs = 0. Reset mid-access abandons the access. A CACHE_RESP_VALID arriving later is ignored.
- States: IDLE, REQ, WAIT, DONE.
- access = MEM_READ_IN | MEM_WRITE_IN. If both are high, treat as a load.
- misaligned: half access with ADDRESS_IN[0] set, or word access with ADDRESS_IN[1:0] nonzero.
- MISALIGNED_OUT = IDLE & access & misaligned. In that case: no request, no stall, state stays IDLE.
- Funct3 values 011/110/111 (loads) and >= 011 (stores) are executed as word accesses.
- IDLE:
  - On access & !misaligned: latch write flag, funct3, address, store data; go REQ.
  - WSTRB: SB 0001<<a[1:0]; SH 0011<<(2*a[1]); SW 1111.
  - WDATA: byte replicated x4, half replicated x2, word as-is.
- REQ: CACHE_REQ_VALID = 1, with addr/wdata/wstrb held stable until CACHE_REQ_READY. On handshake: store -> DONE; load -> WAIT.
- WAIT: on CACHE_RESP_VALID, register the extended result into DATA_CACHE_OUT_DATA, then go DONE.
  - Lane select: byte = word >> 8*a[1:0]; half = word >> 16*a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- DONE: one cycle. LOAD_DONE = 1 if the access was a load. Then go IDLE unconditionally; the same instruction is not relaunched.
- STALL_OUT = (IDLE & access & !misaligned) | REQ | WAIT. It is low in DONE, so the pipeline advances at the end of DONE.
- Minimum latency with ready = 1 and response one cycle after handshake: load 4 cycles (IDLE, REQ, WAIT, DONE); store 3 cycles.
- DATA_CACHE_OUT_DATA holds its last load value across stores and idle cycles.
- CACHE_RESP_VALID outside WAIT is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101, F3_SB=000, F3_SH=001, F3_SW=010).
  - FSM state encoding.
  - DATA_WIDTH/ADDR_WIDTH defaults.
- One combinational sub-module, load_align_extend: inputs word, addr[1:0], funct3; output extended 32-bit value.

Test Plan:
- LW at 0x100, READY = 1, RESP 0xDEADBEEF one cycle later -> REQ_ADDR 0x100, WSTRB 0; DATA_CACHE_OUT_DATA = 0xDEADBEEF; LOAD_DONE pulses in 4th cycle; STALL_OUT high for exactly 3 cycles.
- LB at 0x103, resp 0x80FF7F01 -> REQ_ADDR 0x100; result 0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x102 -> 0xFFFF80FF.
- SB at 0x201, STORE_DATA 0x123456AB, READY held low 3 cycles -> VALID, addr 0x200, WDATA 0xABABABAB, WSTRB 0010 all stable for 4 cycles; DONE with LOAD_DONE = 0; DATA_CACHE_OUT_DATA unchanged.
- LW at 0x102 -> MISALIGNED_OUT = 1, STALL_OUT = 0, CACHE_REQ_VALID never asserted. SH at 0x203 -> same.
- RST_N pulsed low while in WAIT, stray RESP_VALID after release -> IDLE; VALID = 0; DATA_CACHE_OUT_DATA = 0; LOAD_DONE stays 0.
- Back-to-back LW 0x10 then SW 0x14 -> second access begins in IDLE the cycle after DONE; no request is dropped or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 codes,
// FSM encoding and access-size decoding.
package lsu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Unused funct3 encodings fall through to a full word access.
    function automatic access_size_e access_size(input logic is_store, input logic [2:0] funct3);
        access_size_e size;
        size = SZ_WORD;
        if (is_store) begin
            case (funct3)
                F3_SB:   size = SZ_BYTE;
                F3_SH:   size = SZ_HALF;
                default: size = SZ_WORD;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: size = SZ_BYTE;
                F3_LH, F3_LHU: size = SZ_HALF;
                default:       size = SZ_WORD;
            endcase
        end
        return size;
    endfunction

    function automatic logic is_misaligned(input access_size_e size, input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-cache port of the load/store unit: a valid/ready request channel and
// a valid-only response channel.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = lsu_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = lsu_pkg::DEFAULT_ADDR_WIDTH
);
    // Request transfers on a rising edge where VALID and READY are both high;
    // once raised, VALID and the payload stay unchanged until that edge. A
    // response is a single cycle of RESP_VALID and cannot be back-pressured.
    logic                  CACHE_REQ_VALID;
    logic                  CACHE_REQ_READY;
    logic                  CACHE_REQ_WRITE;
    logic [ADDR_WIDTH-1:0] CACHE_REQ_ADDR;
    logic [DATA_WIDTH-1:0] CACHE_REQ_WDATA;
    logic [3:0]            CACHE_REQ_WSTRB;
    logic                  CACHE_RESP_VALID;
    logic [DATA_WIDTH-1:0] CACHE_RESP_DATA;

    modport master (
        output CACHE_REQ_VALID, CACHE_REQ_WRITE, CACHE_REQ_ADDR,
        output CACHE_REQ_WDATA, CACHE_REQ_WSTRB,
        input  CACHE_REQ_READY, CACHE_RESP_VALID, CACHE_RESP_DATA
    );

    modport slave (
        input  CACHE_REQ_VALID, CACHE_REQ_WRITE, CACHE_REQ_ADDR,
        input  CACHE_REQ_WDATA, CACHE_REQ_WSTRB,
        output CACHE_REQ_READY, CACHE_RESP_VALID, CACHE_RESP_DATA
    );

endinterface

// File: rtl/load_align_extend.sv
// Picks the addressed byte/half out of a cache word and sign- or zero-extends
// it according to the load funct3.
module load_align_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] extended
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[7:0];
        case (addr)
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            2'd3:    lane_byte = word[31:24];
            default: lane_byte = word[7:0];
        endcase
        lane_half = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        extended = word;
        case (funct3)
            F3_LB:   extended = {{24{lane_byte[7]}}, lane_byte};
            F3_LH:   extended = {{16{lane_half[15]}}, lane_half};
            F3_LBU:  extended = {24'd0, lane_byte};
            F3_LHU:  extended = {16'd0, lane_half};
            default: extended = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding data-cache access at a time,
// stalling the pipeline until the access has completed.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MEM_READ_IN,
    input  logic                  MEM_WRITE_IN,
    input  logic [2:0]            FUNCT3_IN,
    input  logic [ADDR_WIDTH-1:0] ADDRESS_IN,
    input  logic [DATA_WIDTH-1:0] STORE_DATA_IN,
    load_store_unit_if.master     cache,
    output logic [DATA_WIDTH-1:0] DATA_CACHE_OUT_DATA,
    output logic                  LOAD_DONE,
    output logic                  STALL_OUT,
    output logic                  MISALIGNED_OUT,
    output lsu_state_e            DEBUG_STATE
);

    lsu_state_e            state;
    logic                  req_valid;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [1:0]            req_offset;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [3:0]            req_wstrb;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_done;

    logic                  access;
    logic                  is_store;
    access_size_e          size;
    logic                  misaligned;
    logic                  launch;
    logic [DATA_WIDTH-1:0] next_wdata;
    logic [3:0]            next_wstrb;
    logic [DATA_WIDTH-1:0] extended;

    // A simultaneous read and write request is executed as a load.
    assign access     = MEM_READ_IN | MEM_WRITE_IN;
    assign is_store   = MEM_WRITE_IN & ~MEM_READ_IN;
    assign size       = access_size(is_store, FUNCT3_IN);
    assign misaligned = is_misaligned(size, ADDRESS_IN[1:0]);
    assign launch     = (state == ST_IDLE) & access & ~misaligned;

    assign MISALIGNED_OUT = (state == ST_IDLE) & access & misaligned;
    assign STALL_OUT      = launch | (state == ST_REQ) | (state == ST_WAIT);

    always_comb begin
        next_wdata = STORE_DATA_IN;
        next_wstrb = 4'b1111;
        case (size)
            SZ_BYTE: begin
                next_wdata = {4{STORE_DATA_IN[7:0]}};
                next_wstrb = 4'b0001 << ADDRESS_IN[1:0];
            end
            SZ_HALF: begin
                next_wdata = {2{STORE_DATA_IN[15:0]}};
                next_wstrb = 4'b0011 << {ADDRESS_IN[1], 1'b0};
            end
            default: begin
                next_wdata = STORE_DATA_IN;
                next_wstrb = 4'b1111;
            end
        endcase
        if (!is_store) begin
            next_wdata = '0;
            next_wstrb = 4'b0000;
        end
    end

    load_align_extend u_align (
        .word     (cache.CACHE_RESP_DATA),
        .addr     (req_offset),
        .funct3   (req_funct3),
        .extended (extended)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            req_valid  <= 1'b0;
            req_write  <= 1'b0;
            req_funct3 <= 3'b000;
            req_offset <= 2'b00;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wstrb  <= 4'b0000;
            load_data  <= '0;
            load_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    load_done <= 1'b0;
                    if (launch) begin
                        req_valid  <= 1'b1;
                        req_write  <= is_store;
                        req_funct3 <= FUNCT3_IN;
                        req_offset <= ADDRESS_IN[1:0];
                        req_addr   <= {ADDRESS_IN[ADDR_WIDTH-1:2], 2'b00};
                        req_wdata  <= next_wdata;
                        req_wstrb  <= next_wstrb;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cache.CACHE_REQ_READY) begin
                        req_valid <= 1'b0;
                        state     <= req_write ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cache.CACHE_RESP_VALID) begin
                        load_data <= extended;
                        load_done <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                // The pipeline advances at the end of DONE, so the same
                // instruction is never seen again in IDLE.
                ST_DONE: begin
                    load_done <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    req_valid <= 1'b0;
                    load_done <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cache.CACHE_REQ_VALID = req_valid;
    assign cache.CACHE_REQ_WRITE = req_write;
    assign cache.CACHE_REQ_ADDR  = req_addr;
    assign cache.CACHE_REQ_WDATA = req_wdata;
    assign cache.CACHE_REQ_WSTRB = req_wstrb;

    assign DATA_CACHE_OUT_DATA = load_data;
    assign LOAD_DONE           = load_done;
    assign DEBUG_STATE         = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment, reset
// during an access and back-to-back accesses.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] data_out;
    logic        load_done;
    logic        stall;
    logic        misaligned;
    lsu_state_e  dbg_state;

    int total = 0;
    int bad = 0;
    int hs_count = 0;

    logic [31:0] obs_addr, obs_wdata, obs_result;
    logic [3:0]  obs_wstrb;
    logic        obs_write, obs_stable, obs_load_done, obs_timeout;
    int          obs_valid_cycles, obs_stall_cycles, obs_done_cycle, obs_ld_pulses;

    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit dut (
        .CLK                 (clk),
        .RST_N               (rst_n),
        .MEM_READ_IN         (mem_read),
        .MEM_WRITE_IN        (mem_write),
        .FUNCT3_IN           (funct3),
        .ADDRESS_IN          (address),
        .STORE_DATA_IN       (store_data),
        .cache               (bus),
        .DATA_CACHE_OUT_DATA (data_out),
        .LOAD_DONE           (load_done),
        .STALL_OUT           (stall),
        .MISALIGNED_OUT      (misaligned),
        .DEBUG_STATE         (dbg_state)
    );

    always @(posedge clk)
        if (rst_n && bus.CACHE_REQ_VALID && bus.CACHE_REQ_READY) hs_count <= hs_count + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one access from the next cycle on, plays the cache (ready after
    // ready_delay valid cycles, response one cycle after a load handshake) and
    // returns at the negedge of the first non-stalled cycle (DONE).
    task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd, input int ready_delay);
        @(posedge clk); #1;
        mem_read = !wr; mem_write = wr; funct3 = f3; address = a; store_data = sd;
        bus.CACHE_REQ_READY = (ready_delay == 0);
        bus.CACHE_RESP_VALID = 1'b0;
        obs_valid_cycles = 0; obs_stall_cycles = 0; obs_done_cycle = 0; obs_ld_pulses = 0;
        obs_stable = 1'b1; obs_timeout = 1'b1; obs_load_done = 1'b0;
        obs_addr = '0; obs_wdata = '0; obs_wstrb = '0; obs_write = 1'b0; obs_result = '0;
        for (int c = 1; c <= 30; c++) begin
            logic hs;
            @(negedge clk);
            if (stall) obs_stall_cycles++;
            if (load_done) obs_ld_pulses++;
            if (bus.CACHE_REQ_VALID) begin
                if (obs_valid_cycles == 0) begin
                    obs_addr = bus.CACHE_REQ_ADDR; obs_wdata = bus.CACHE_REQ_WDATA;
                    obs_wstrb = bus.CACHE_REQ_WSTRB; obs_write = bus.CACHE_REQ_WRITE;
                end else if (obs_addr !== bus.CACHE_REQ_ADDR || obs_wdata !== bus.CACHE_REQ_WDATA ||
                             obs_wstrb !== bus.CACHE_REQ_WSTRB || obs_write !== bus.CACHE_REQ_WRITE) begin
                    obs_stable = 1'b0;
                end
                obs_valid_cycles++;
            end
            hs = bus.CACHE_REQ_VALID && bus.CACHE_REQ_READY;
            if (!stall && obs_stall_cycles > 0) begin
                obs_done_cycle = c; obs_load_done = load_done; obs_result = data_out;
                obs_timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
            bus.CACHE_RESP_VALID = 1'b0;
            if (hs && !wr) begin
                bus.CACHE_RESP_VALID = 1'b1;
                bus.CACHE_RESP_DATA = rd;
            end
            bus.CACHE_REQ_READY = (obs_valid_cycles >= ready_delay);
        end
    endtask

    task automatic end_access();
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        bus.CACHE_REQ_READY = 1'b0; bus.CACHE_RESP_VALID = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; address = '0; store_data = '0;
        bus.CACHE_REQ_READY = 1'b0; bus.CACHE_RESP_VALID = 1'b0; bus.CACHE_RESP_DATA = '0;
        repeat (2) @(negedge clk);
        total++; if (bus.CACHE_REQ_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.CACHE_REQ_VALID); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=00000000", data_out); end
        total++; if (load_done !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_flags got done=%b stall=%b exp 0/0", load_done, stall); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        run_access(1'b0, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL lw_timeout got=%b exp=0", obs_timeout); end
        total++; if (obs_addr !== 32'h100 || obs_wstrb !== 4'b0000 || obs_write !== 1'b0) begin bad++;
            $display("FAIL lw_req got addr=%h wstrb=%b wr=%b exp 00000100/0000/0", obs_addr, obs_wstrb, obs_write); end
        total++; if (obs_result !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", obs_result); end
        total++; if (obs_load_done !== 1'b1 || obs_done_cycle != 4) begin bad++;
            $display("FAIL lw_done got done=%b cycle=%0d exp 1/4", obs_load_done, obs_done_cycle); end
        total++; if (obs_stall_cycles != 3 || obs_ld_pulses != 1) begin bad++;
            $display("FAIL lw_stall got stall=%0d pulses=%0d exp 3/1", obs_stall_cycles, obs_ld_pulses); end
        end_access();
        @(negedge clk);
        total++; if (load_done !== 1'b0 || data_out !== 32'hDEADBEEF || bus.CACHE_REQ_VALID !== 1'b0) begin bad++;
            $display("FAIL lw_after got done=%b data=%h valid=%b exp 0/deadbeef/0", load_done, data_out, bus.CACHE_REQ_VALID); end
    endtask

    task automatic test_byte_half();
        logic [2:0]  f3s [5];
        logic [31:0] addrs [5];
        logic [31:0] exps [5];
        f3s[0] = F3_LB;  addrs[0] = 32'h103; exps[0] = 32'hFFFFFF80;
        f3s[1] = F3_LBU; addrs[1] = 32'h103; exps[1] = 32'h00000080;
        f3s[2] = F3_LH;  addrs[2] = 32'h102; exps[2] = 32'hFFFF80FF;
        f3s[3] = F3_LHU; addrs[3] = 32'h100; exps[3] = 32'h00007F01;
        f3s[4] = F3_LB;  addrs[4] = 32'h101; exps[4] = 32'h0000007F;
        for (int i = 0; i < 5; i++) begin
            run_access(1'b0, f3s[i], addrs[i], 32'h0, 32'h80FF7F01, 0);
            total++; if (obs_result !== exps[i] || obs_timeout !== 1'b0) begin bad++;
                $display("FAIL subword_%0d got=%h timeout=%b exp=%h", i, obs_result, obs_timeout, exps[i]); end
            total++; if (obs_addr !== 32'h100) begin bad++; $display("FAIL subword_addr_%0d got=%h exp=00000100", i, obs_addr); end
            end_access();
        end
    endtask

    task automatic test_store();
        run_access(1'b1, F3_SB, 32'h201, 32'h123456AB, 32'h0, 3);
        total++; if (obs_valid_cycles != 4 || obs_stable !== 1'b1) begin bad++;
            $display("FAIL sb_hold got valid_cycles=%0d stable=%b exp 4/1", obs_valid_cycles, obs_stable); end
        total++; if (obs_addr !== 32'h200 || obs_wdata !== 32'hABABABAB || obs_wstrb !== 4'b0010 || obs_write !== 1'b1) begin bad++;
            $display("FAIL sb_req got addr=%h wdata=%h wstrb=%b wr=%b", obs_addr, obs_wdata, obs_wstrb, obs_write); end
        total++; if (obs_load_done !== 1'b0 || obs_ld_pulses != 0 || obs_done_cycle != 6) begin bad++;
            $display("FAIL sb_done got done=%b pulses=%0d cycle=%0d exp 0/0/6", obs_load_done, obs_ld_pulses, obs_done_cycle); end
        total++; if (obs_result !== 32'h0000007F) begin bad++; $display("FAIL sb_keep_data got=%h exp=0000007f", obs_result); end
        end_access();
        run_access(1'b1, F3_SH, 32'h202, 32'h0000BEEF, 32'h0, 0);
        total++; if (obs_wdata !== 32'hBEEFBEEF || obs_wstrb !== 4'b1100 || obs_addr !== 32'h200) begin bad++;
            $display("FAIL sh_req got addr=%h wdata=%h wstrb=%b", obs_addr, obs_wdata, obs_wstrb); end
        total++; if (obs_done_cycle != 3 || obs_stall_cycles != 2) begin bad++;
            $display("FAIL sh_latency got cycle=%0d stall=%0d exp 3/2", obs_done_cycle, obs_stall_cycles); end
        end_access();
    endtask

    task automatic test_misaligned();
        logic        wrs [3];
        logic [2:0]  f3s [3];
        logic [31:0] addrs [3];
        int          h0;
        wrs[0] = 1'b0; f3s[0] = F3_LW; addrs[0] = 32'h102;
        wrs[1] = 1'b1; f3s[1] = F3_SH; addrs[1] = 32'h203;
        wrs[2] = 1'b0; f3s[2] = F3_LH; addrs[2] = 32'h101;
        h0 = hs_count;
        for (int i = 0; i < 3; i++) begin
            int wrong;
            wrong = 0;
            @(posedge clk); #1;
            mem_read = !wrs[i]; mem_write = wrs[i]; funct3 = f3s[i]; address = addrs[i];
            bus.CACHE_REQ_READY = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (misaligned !== 1'b1 || stall !== 1'b0 || bus.CACHE_REQ_VALID !== 1'b0) wrong++;
            end
            total++; if (wrong != 0) begin bad++; $display("FAIL misaligned_%0d got bad_cycles=%0d exp=0", i, wrong); end
            end_access();
        end
        @(negedge clk);
        total++; if (hs_count != h0) begin bad++; $display("FAIL misaligned_handshakes got=%0d exp=%0d", hs_count, h0); end
    endtask

    task automatic test_reset_mid();
        int wrong;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_LW; address = 32'h300;
        bus.CACHE_REQ_READY = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        total++; if (dbg_state !== ST_WAIT || stall !== 1'b1) begin bad++;
            $display("FAIL rst_mid_wait got state=%0d stall=%b exp %0d/1", dbg_state, stall, ST_WAIT); end
        mem_read = 1'b0; bus.CACHE_REQ_READY = 1'b0;
        rst_n = 1'b0;
        #2;
        total++; if (dbg_state !== ST_IDLE || data_out !== 32'h0 || bus.CACHE_REQ_VALID !== 1'b0) begin bad++;
            $display("FAIL rst_mid_clear got state=%0d data=%h valid=%b", dbg_state, data_out, bus.CACHE_REQ_VALID); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.CACHE_RESP_VALID = 1'b1; bus.CACHE_RESP_DATA = 32'h55AA55AA;
        @(posedge clk); #1;
        bus.CACHE_RESP_VALID = 1'b0;
        wrong = 0;
        repeat (3) begin
            @(negedge clk);
            if (load_done !== 1'b0 || data_out !== 32'h0 || bus.CACHE_REQ_VALID !== 1'b0 || stall !== 1'b0) wrong++;
        end
        total++; if (wrong != 0) begin bad++; $display("FAIL rst_mid_stray_resp got bad_cycles=%0d exp=0", wrong); end
    endtask

    task automatic test_back_to_back();
        int h0;
        int first_cycle;
        logic [31:0] first_result;
        h0 = hs_count;
        run_access(1'b0, F3_LW, 32'h10, 32'h0, 32'hCAFEF00D, 0);
        first_cycle = obs_done_cycle; first_result = obs_result;
        run_access(1'b1, F3_SW, 32'h14, 32'hA5A51234, 32'h0, 0);
        total++; if (first_cycle != 4 || first_result !== 32'hCAFEF00D) begin bad++;
            $display("FAIL b2b_load got cycle=%0d data=%h exp 4/cafef00d", first_cycle, first_result); end
        total++; if (obs_done_cycle != 3 || obs_stall_cycles != 2) begin bad++;
            $display("FAIL b2b_store_timing got cycle=%0d stall=%0d exp 3/2", obs_done_cycle, obs_stall_cycles); end
        total++; if (obs_addr !== 32'h14 || obs_wdata !== 32'hA5A51234 || obs_wstrb !== 4'b1111 || obs_write !== 1'b1) begin bad++;
            $display("FAIL b2b_store_req got addr=%h wdata=%h wstrb=%b wr=%b", obs_addr, obs_wdata, obs_wstrb, obs_write); end
        total++; if (obs_result !== 32'hCAFEF00D || obs_load_done !== 1'b0) begin bad++;
            $display("FAIL b2b_store_keep got data=%h done=%b exp cafef00d/0", obs_result, obs_load_done); end
        end_access();
        repeat (2) @(negedge clk);
        total++; if (hs_count - h0 != 2) begin bad++; $display("FAIL b2b_handshakes got=%0d exp=2", hs_count - h0); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_half();
        test_store();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
